// File: rtl/ctrl_sequencer_if.sv
// rtl/ctrl_sequencer_if.sv - control strobe bundle between sequencer and datapath
interface ctrl_sequencer_if #(
    parameter int IR_WIDTH = 32
);
    // datapath -> sequencer
    logic [IR_WIDTH-1:0] IR;
    logic                Stop;

    // bus drive enables
    logic PCout, Zlowout, MDRout;
    // register load enables
    logic MARin, Zin, PCin, MDRin, IRin, Yin;
    // ALU and memory controls
    logic IncPC, Read;
    logic ADD, SUB, AND, OR;
    // register-field selects and general-register controls
    logic Gra, Grb, Grc;
    logic Rin, Rout, Cout;
    // status
    logic Run, Illegal;

    modport master (
        input  IR, Stop,
        output PCout, Zlowout, MDRout,
        output MARin, Zin, PCin, MDRin, IRin, Yin,
        output IncPC, Read, ADD, SUB, AND, OR,
        output Gra, Grb, Grc, Rin, Rout, Cout,
        output Run, Illegal
    );

    modport slave (
        output IR, Stop,
        input  PCout, Zlowout, MDRout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin,
        input  IncPC, Read, ADD, SUB, AND, OR,
        input  Gra, Grb, Grc, Rin, Rout, Cout,
        input  Run, Illegal
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - hardwired fetch/decode/execute control sequencer
module ctrl_sequencer #(
    parameter int IR_WIDTH = 32,
    parameter int OP_MSB   = 31
) (
    input  logic              Clock,
    input  logic              Resetn,
    ctrl_sequencer_if.master  bus
);

    // Fall back to the low field if the opcode position is out of range.
    localparam int OpMsb = (OP_MSB >= 4 && OP_MSB < IR_WIDTH) ? OP_MSB : 4;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_HALT = 3'd7
    } state_e;

    state_e     state_q, state_d;
    logic       stop_q, stop_d;
    logic [4:0] opcode;
    logic       is_rr, is_imm, is_alu;
    logic       stop_pending;

    assign opcode = bus.IR[OpMsb -: 5];
    assign is_rr  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_OR);
    assign is_imm = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign is_alu = is_rr || is_imm;

    // A Stop arriving in the last cycle of an instruction still counts at that boundary.
    assign stop_pending = stop_q || bus.Stop;

    // State register and sticky stop flag; reset abandons any instruction in flight.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_RST;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
        end
    end

    // Next state and Moore strobes decoded from the current state and IR opcode.
    always_comb begin
        state_d     = state_q;
        stop_d      = stop_pending;
        bus.PCout   = 1'b0;
        bus.Zlowout = 1'b0;
        bus.MDRout  = 1'b0;
        bus.MARin   = 1'b0;
        bus.Zin     = 1'b0;
        bus.PCin    = 1'b0;
        bus.MDRin   = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Read    = 1'b0;
        bus.ADD     = 1'b0;
        bus.SUB     = 1'b0;
        bus.AND     = 1'b0;
        bus.OR      = 1'b0;
        bus.Gra     = 1'b0;
        bus.Grb     = 1'b0;
        bus.Grc     = 1'b0;
        bus.Rin     = 1'b0;
        bus.Rout    = 1'b0;
        bus.Cout    = 1'b0;
        bus.Run     = 1'b1;
        bus.Illegal = 1'b0;

        unique case (state_q)
            ST_RST: begin
                bus.Run = 1'b0;
                state_d = stop_pending ? ST_HALT : ST_T0;
            end
            ST_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
                state_d   = ST_T1;
            end
            ST_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                state_d     = ST_T2;
            end
            ST_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = ST_T3;
            end
            ST_T3: begin
                if (is_alu) begin
                    bus.Grb  = 1'b1;
                    bus.Rout = 1'b1;
                    bus.Yin  = 1'b1;
                    state_d  = ST_T4;
                end else if (opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    bus.Illegal = (opcode != OP_NOP);
                    state_d     = stop_pending ? ST_HALT : ST_T0;
                end
            end
            ST_T4: begin
                // Register-register ops take operand C from Rc, immediates from the IR C field.
                bus.Grc  = is_rr;
                bus.Rout = is_rr;
                bus.Cout = is_imm;
                bus.Zin  = is_alu;
                bus.ADD  = (opcode == OP_ADD) || (opcode == OP_ADDI);
                bus.SUB  = (opcode == OP_SUB);
                bus.AND  = (opcode == OP_AND) || (opcode == OP_ANDI);
                bus.OR   = (opcode == OP_OR)  || (opcode == OP_ORI);
                state_d  = ST_T5;
            end
            ST_T5: begin
                bus.Zlowout = 1'b1;
                bus.Gra     = 1'b1;
                bus.Rin     = 1'b1;
                state_d     = stop_pending ? ST_HALT : ST_T0;
            end
            ST_HALT: begin
                bus.Run = 1'b0;
                state_d = ST_HALT;
            end
            default: begin
                bus.Run = 1'b0;
                state_d = ST_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - directed self-checking bench for ctrl_sequencer
module tb_ctrl_sequencer;

    logic Clock;
    logic Resetn;

    ctrl_sequencer_if #(.IR_WIDTH(32)) bus ();

    ctrl_sequencer #(.IR_WIDTH(32), .OP_MSB(31)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Bit positions of the packed observation vector.
    localparam logic [22:0] B_ILL   = 23'd1 << 0;
    localparam logic [22:0] B_RUN   = 23'd1 << 1;
    localparam logic [22:0] B_COUT  = 23'd1 << 2;
    localparam logic [22:0] B_ROUT  = 23'd1 << 3;
    localparam logic [22:0] B_RIN   = 23'd1 << 4;
    localparam logic [22:0] B_GRC   = 23'd1 << 5;
    localparam logic [22:0] B_GRB   = 23'd1 << 6;
    localparam logic [22:0] B_GRA   = 23'd1 << 7;
    localparam logic [22:0] B_OR    = 23'd1 << 8;
    localparam logic [22:0] B_AND   = 23'd1 << 9;
    localparam logic [22:0] B_SUB   = 23'd1 << 10;
    localparam logic [22:0] B_ADD   = 23'd1 << 11;
    localparam logic [22:0] B_READ  = 23'd1 << 12;
    localparam logic [22:0] B_INCPC = 23'd1 << 13;
    localparam logic [22:0] B_YIN   = 23'd1 << 14;
    localparam logic [22:0] B_IRIN  = 23'd1 << 15;
    localparam logic [22:0] B_MDRIN = 23'd1 << 16;
    localparam logic [22:0] B_PCIN  = 23'd1 << 17;
    localparam logic [22:0] B_ZIN   = 23'd1 << 18;
    localparam logic [22:0] B_MARIN = 23'd1 << 19;
    localparam logic [22:0] B_MDROUT= 23'd1 << 20;
    localparam logic [22:0] B_ZLOW  = 23'd1 << 21;
    localparam logic [22:0] B_PCOUT = 23'd1 << 22;

    localparam logic [22:0] E_T0  = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
    localparam logic [22:0] E_T1  = B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_RUN;
    localparam logic [22:0] E_T2  = B_MDROUT | B_IRIN | B_RUN;
    localparam logic [22:0] E_T3A = B_GRB | B_ROUT | B_YIN | B_RUN;
    localparam logic [22:0] E_T5  = B_ZLOW | B_GRA | B_RIN | B_RUN;
    localparam logic [22:0] E_RUN = B_RUN;
    localparam logic [22:0] E_OFF = 23'd0;

    logic [22:0] obs;
    assign obs = {bus.PCout, bus.Zlowout, bus.MDRout, bus.MARin, bus.Zin, bus.PCin,
                  bus.MDRin, bus.IRin, bus.Yin, bus.IncPC, bus.Read,
                  bus.ADD, bus.SUB, bus.AND, bus.OR,
                  bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.Cout,
                  bus.Run, bus.Illegal};

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch_checks(input string tag);
        check_eq({tag, "_t0"}, {9'd0, obs}, {9'd0, E_T0});
        step();
        check_eq({tag, "_t1"}, {9'd0, obs}, {9'd0, E_T1});
        step();
        check_eq({tag, "_t2"}, {9'd0, obs}, {9'd0, E_T2});
        step();
    endtask

    bit mon_en = 1'b0;

    // Structural exclusivity checked every cycle, away from the active edge.
    always @(negedge Clock) begin
        if (mon_en) begin
            check_eq("bus_drv_1hot",
                     32'($countones({bus.PCout, bus.Zlowout, bus.MDRout, bus.Rout, bus.Cout}) <= 1), 32'd1);
            check_eq("alu_1hot",
                     32'($countones({bus.ADD, bus.SUB, bus.AND, bus.OR}) <= 1), 32'd1);
            check_eq("gr_1hot",
                     32'($countones({bus.Gra, bus.Grb, bus.Grc}) <= 1), 32'd1);
        end
    end

    initial begin
        Resetn   = 1'b0;
        bus.IR   = 32'h2A2B8000;
        bus.Stop = 1'b0;
        mon_en   = 1'b1;
        step();
        step();
        check_eq("rst_hold", {9'd0, obs}, {9'd0, E_OFF});
        Resetn = 1'b1;
        #1;
        check_eq("rst_idle", {9'd0, obs}, {9'd0, E_OFF});
        step();

        // and: full six-cycle ALU instruction
        fetch_checks("and");
        check_eq("and_t3", {9'd0, obs}, {9'd0, E_T3A});
        step();
        check_eq("and_t4", {9'd0, obs}, {9'd0, B_GRC | B_ROUT | B_AND | B_ZIN | B_RUN});
        step();
        check_eq("and_t5", {9'd0, obs}, {9'd0, E_T5});
        step();

        // addi: IR changes during fetch, decode uses the new opcode from T3
        bus.IR = 32'h60800005;
        fetch_checks("addi");
        check_eq("addi_t3", {9'd0, obs}, {9'd0, E_T3A});
        step();
        check_eq("addi_t4", {9'd0, obs}, {9'd0, B_COUT | B_ADD | B_ZIN | B_RUN});
        step();
        check_eq("addi_t5", {9'd0, obs}, {9'd0, E_T5});
        step();

        // nop: four cycles
        bus.IR = 32'hD0000000;
        fetch_checks("nop");
        check_eq("nop_t3", {9'd0, obs}, {9'd0, E_RUN});
        step();

        // illegal: one-cycle pulse then refetch
        bus.IR = 32'hF8000000;
        fetch_checks("ill");
        check_eq("ill_t3", {9'd0, obs}, {9'd0, E_RUN | B_ILL});
        step();

        // add with Stop pulsed during T4: T5 completes, then HALT
        bus.IR = 32'h18000000;
        fetch_checks("add");
        check_eq("add_t3", {9'd0, obs}, {9'd0, E_T3A});
        step();
        check_eq("add_t4", {9'd0, obs}, {9'd0, B_GRC | B_ROUT | B_ADD | B_ZIN | B_RUN});
        bus.Stop = 1'b1;
        step();
        bus.Stop = 1'b0;
        check_eq("add_t5", {9'd0, obs}, {9'd0, E_T5});
        step();
        for (int i = 0; i < 4; i++) begin
            check_eq("stop_halt", {9'd0, obs}, {9'd0, E_OFF});
            step();
        end

        // reset out of HALT, then sub interrupted by an asynchronous reset in T4
        Resetn = 1'b0;
        #1;
        check_eq("rst_from_halt", {9'd0, obs}, {9'd0, E_OFF});
        bus.IR = 32'h20000000;
        step();
        Resetn = 1'b1;
        step();
        fetch_checks("sub");
        check_eq("sub_t3", {9'd0, obs}, {9'd0, E_T3A});
        step();
        check_eq("sub_t4", {9'd0, obs}, {9'd0, B_GRC | B_ROUT | B_SUB | B_ZIN | B_RUN});
        #1;
        Resetn = 1'b0;
        #1;
        check_eq("rst_mid_t4", {9'd0, obs}, {9'd0, E_OFF});
        step();
        check_eq("rst_mid_hold", {9'd0, obs}, {9'd0, E_OFF});
        Resetn = 1'b1;
        bus.IR = 32'hD8000000;
        step();

        // halt: four cycles then HALT held indefinitely
        fetch_checks("halt");
        check_eq("halt_t3", {9'd0, obs}, {9'd0, E_RUN});
        step();
        for (int i = 0; i < 22; i++) begin
            check_eq("halt_hold", {9'd0, obs}, {9'd0, E_OFF});
            step();
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
